// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch channel (i_*), load/store channel (d_*)
// and the shared downstream memory port (m_*).
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] i_addr;
   logic              i_req_valid;
   logic              i_req_ready;
   logic [DATA_W-1:0] i_rdata;
   logic              i_rvalid;
   logic              i_rready;

   logic [ADDR_W-1:0] d_addr;
   logic              d_mem_read;
   logic              d_mem_write;
   logic [DATA_W-1:0] d_wdata;
   logic [STRB_W-1:0] d_wstrb;
   logic              d_req_ready;
   logic [DATA_W-1:0] d_rdata;
   logic              d_rvalid;
   logic              d_rready;

   logic [ADDR_W-1:0] m_addr;
   logic              m_req_valid;
   logic              m_wen;
   logic [DATA_W-1:0] m_wdata;
   logic [STRB_W-1:0] m_wstrb;
   logic              m_req_ready;
   logic [DATA_W-1:0] m_rdata;
   logic              m_rvalid;
   logic              m_rready;

   // Arbiter side
   modport slave (
      input  i_addr, i_req_valid, i_rready,
      input  d_addr, d_mem_read, d_mem_write, d_wdata, d_wstrb, d_rready,
      input  m_req_ready, m_rdata, m_rvalid,
      output i_req_ready, i_rdata, i_rvalid,
      output d_req_ready, d_rdata, d_rvalid,
      output m_addr, m_req_valid, m_wen, m_wdata, m_wstrb, m_rready
   );

   // Core + memory side
   modport master (
      output i_addr, i_req_valid, i_rready,
      output d_addr, d_mem_read, d_mem_write, d_wdata, d_wstrb, d_rready,
      output m_req_ready, m_rdata, m_rvalid,
      input  i_req_ready, i_rdata, i_rvalid,
      input  d_req_ready, d_rdata, d_rvalid,
      input  m_addr, m_req_valid, m_wen, m_wdata, m_wstrb, m_rready
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-channel (fetch / load-store) arbiter onto one memory port, one transaction
// in flight. Optional performance counters under `MEM_ARB_PERF_CNT_EN.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   mem_arbiter_if.slave bus,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_conflict
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_own;
   logic   w_own_nxt;
   logic   r_last;
   logic   w_last_nxt;

   logic   w_i_req;
   logic   w_d_req;
   logic   w_grant_ch;

   logic [ADDR_W-1:0] w_m_addr;
   logic              w_m_req_valid;
   logic              w_m_wen;
   logic [DATA_W-1:0] w_m_wdata;
   logic [STRB_W-1:0] w_m_wstrb;
   logic              w_m_rready;
   logic              w_i_req_ready;
   logic [DATA_W-1:0] w_i_rdata;
   logic              w_i_rvalid;
   logic              w_d_req_ready;
   logic [DATA_W-1:0] w_d_rdata;
   logic              w_d_rvalid;

   assign w_i_req = bus.i_req_valid;
   assign w_d_req = bus.d_mem_read | bus.d_mem_write;

   // Channel 1 = data. On a conflict round-robin picks whoever did not win last.
   always_comb begin
      w_grant_ch = w_d_req;
      if (w_i_req && w_d_req) begin
         w_grant_ch = (FIXED_PRIO != 0) ? 1'b1 : ~r_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_own   <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_own   <= w_own_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_own_nxt     = r_own;
      w_last_nxt    = r_last;
      w_m_addr      = '0;
      w_m_req_valid = 1'b0;
      w_m_wen       = 1'b0;
      w_m_wdata     = '0;
      w_m_wstrb     = '0;
      w_m_rready    = 1'b0;
      w_i_req_ready = 1'b0;
      w_i_rdata     = '0;
      w_i_rvalid    = 1'b0;
      w_d_req_ready = 1'b0;
      w_d_rdata     = '0;
      w_d_rvalid    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_i_req || w_d_req) begin
               w_own_nxt   = w_grant_ch;
               w_last_nxt  = w_grant_ch;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            w_m_req_valid = 1'b1;
            if (r_own) begin
               w_m_addr      = bus.d_addr;
               w_m_wen       = bus.d_mem_write;
               w_m_wdata     = bus.d_wdata;
               w_m_wstrb     = bus.d_wstrb;
               w_d_req_ready = bus.m_req_ready;
            end else begin
               w_m_addr      = bus.i_addr;
               w_i_req_ready = bus.m_req_ready;
            end
            if (bus.m_req_ready) begin
               w_state_nxt = (r_own && bus.d_mem_write) ? S_IDLE : S_RESP;
            end
         end
         S_RESP: begin
            if (r_own) begin
               w_d_rvalid = bus.m_rvalid;
               w_d_rdata  = bus.m_rdata;
               w_m_rready = bus.d_rready;
            end else begin
               w_i_rvalid = bus.m_rvalid;
               w_i_rdata  = bus.m_rdata;
               w_m_rready = bus.i_rready;
            end
            if (bus.m_rvalid && w_m_rready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.m_addr      = w_m_addr;
   assign bus.m_req_valid = w_m_req_valid;
   assign bus.m_wen       = w_m_wen;
   assign bus.m_wdata     = w_m_wdata;
   assign bus.m_wstrb     = w_m_wstrb;
   assign bus.m_rready    = w_m_rready;
   assign bus.i_req_ready = w_i_req_ready;
   assign bus.i_rdata     = w_i_rdata;
   assign bus.i_rvalid    = w_i_rvalid;
   assign bus.d_req_ready = w_d_req_ready;
   assign bus.d_rdata     = w_d_rdata;
   assign bus.d_rvalid    = w_d_rvalid;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] r_perf_i;
   logic [31:0] r_perf_d;
   logic [31:0] r_perf_c;

   // With one transaction in flight, both requesting always leaves one waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_i <= '0;
         r_perf_d <= '0;
         r_perf_c <= '0;
      end else begin
         if (r_state == S_IDLE && (w_i_req || w_d_req)) begin
            if (w_grant_ch) r_perf_d <= r_perf_d + 32'd1;
            else            r_perf_i <= r_perf_i + 32'd1;
         end
         if (w_i_req && w_d_req) begin
            r_perf_c <= r_perf_c + 32'd1;
         end
      end
   end

   assign perf_i_grants = r_perf_i;
   assign perf_d_grants = r_perf_d;
   assign perf_conflict = r_perf_c;
`else
   assign perf_i_grants = '0;
   assign perf_d_grants = '0;
   assign perf_conflict = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fp ();

   logic [31:0] pi, pd, pc;
   logic [31:0] fpi, fpd, fpc;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_dut (
      .clk(clk), .rst(rst), .bus(bus),
      .perf_i_grants(pi), .perf_d_grants(pd), .perf_conflict(pc)
   );

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_dut_fp (
      .clk(clk), .rst(rst), .bus(bus_fp),
      .perf_i_grants(fpi), .perf_d_grants(fpd), .perf_conflict(fpc)
   );

   int tests = 0;
   int fails = 0;
   int m_conf = 0;
   int m_pi = 0;
   int m_pd = 0;

   // Conflict cycles as seen from the stimulus: both channels requesting.
   always @(posedge clk) begin
      if (rst) m_conf <= 0;
      else if (bus.i_req_valid && (bus.d_mem_read || bus.d_mem_write)) m_conf <= m_conf + 1;
   end

   task automatic clear_inputs();
      bus.i_addr = '0; bus.i_req_valid = 0; bus.i_rready = 0;
      bus.d_addr = '0; bus.d_mem_read = 0; bus.d_mem_write = 0;
      bus.d_wdata = '0; bus.d_wstrb = '0; bus.d_rready = 0;
      bus.m_req_ready = 0; bus.m_rdata = '0; bus.m_rvalid = 0;
      bus_fp.i_addr = '0; bus_fp.i_req_valid = 0; bus_fp.i_rready = 0;
      bus_fp.d_addr = '0; bus_fp.d_mem_read = 0; bus_fp.d_mem_write = 0;
      bus_fp.d_wdata = '0; bus_fp.d_wstrb = '0; bus_fp.d_rready = 0;
      bus_fp.m_req_ready = 0; bus_fp.m_rdata = '0; bus_fp.m_rvalid = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_pi = 0;
      m_pd = 0;
   endtask

   task automatic test_reset();
      logic [31:0] e_pi, e_pd, e_pc;
      do_reset();
      #1;
      tests++;
      if ({bus.i_req_ready, bus.i_rvalid, bus.i_rdata, bus.d_req_ready, bus.d_rvalid, bus.d_rdata,
           bus.m_addr, bus.m_req_valid, bus.m_wen, bus.m_wdata, bus.m_wstrb, bus.m_rready} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: m_req_valid=%b m_addr=%h i_rvalid=%b d_rvalid=%b required all 0",
                  bus.m_req_valid, bus.m_addr, bus.i_rvalid, bus.d_rvalid);
      end
      e_pi = 0; e_pd = 0; e_pc = 0;
      tests++;
      if ({pi, pd, pc} !== {e_pi, e_pd, e_pc}) begin
         fails++;
         $display("FAIL reset_perf: got %0d/%0d/%0d required 0/0/0", pi, pd, pc);
      end
   endtask

   task automatic test_fetch();
      do_reset();
      bus.i_addr = 32'h8000_0000; bus.i_req_valid = 1; bus.m_req_ready = 1; bus.i_rready = 1;
      #1;
      tests++;
      if (bus.m_req_valid !== 1'b0) begin
         fails++; $display("FAIL fetch_grant_cycle: m_req_valid=%b required 0", bus.m_req_valid);
      end
      @(negedge clk);
      tests++;
      if ({bus.m_req_valid, bus.m_addr, bus.m_wen, bus.m_wdata, bus.m_wstrb, bus.i_req_ready, bus.d_req_ready}
          !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL fetch_req: valid=%b addr=%h wen=%b i_rdy=%b d_rdy=%b required 1 80000000 0 1 0",
                  bus.m_req_valid, bus.m_addr, bus.m_wen, bus.i_req_ready, bus.d_req_ready);
      end
      @(negedge clk);
      bus.i_req_valid = 0; bus.m_req_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0000_0013;
      #1;
      tests++;
      if ({bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.m_rready} !== {1'b1, 32'h13, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL fetch_resp: i_rvalid=%b i_rdata=%h d_rvalid=%b m_rready=%b required 1 00000013 0 1",
                  bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.m_rready);
      end
      @(negedge clk);
      bus.m_rvalid = 0; bus.m_rdata = '0;
      #1;
      tests++;
      if ({bus.m_req_valid, bus.i_rvalid, bus.m_rready} !== 3'b000) begin
         fails++;
         $display("FAIL fetch_idle: m_req_valid=%b i_rvalid=%b m_rready=%b required 0 0 0",
                  bus.m_req_valid, bus.i_rvalid, bus.m_rready);
      end
   endtask

   task automatic test_store();
      do_reset();
      bus.d_addr = 32'h100; bus.d_mem_write = 1; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
      bus.m_req_ready = 1;
      #1;
      tests++;
      if (bus.m_req_valid !== 1'b0) begin
         fails++; $display("FAIL store_grant_cycle: m_req_valid=%b required 0", bus.m_req_valid);
      end
      @(negedge clk);
      tests++;
      if ({bus.m_req_valid, bus.m_wen, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.d_req_ready, bus.i_req_ready}
          !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL store_req: wen=%b addr=%h wdata=%h wstrb=%h d_rdy=%b required 1 00000100 deadbeef f 1",
                  bus.m_wen, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.d_req_ready);
      end
      @(negedge clk);
      bus.d_mem_write = 0; bus.m_req_ready = 0;
      #1;
      tests++;
      if ({bus.m_req_valid, bus.m_rready, bus.d_rvalid, bus.d_req_ready} !== 4'b0000) begin
         fails++;
         $display("FAIL store_no_resp: m_req_valid=%b m_rready=%b d_rvalid=%b d_rdy=%b required 0 0 0 0",
                  bus.m_req_valid, bus.m_rready, bus.d_rvalid, bus.d_req_ready);
      end
   endtask

   task automatic test_conflict();
      int rr[$];
      int fp[$];
      do_reset();
      bus.i_req_valid = 1; bus.d_mem_read = 1; bus.m_req_ready = 1; bus.m_rvalid = 1;
      bus.i_rready = 1; bus.d_rready = 1; bus.m_rdata = $urandom;
      bus_fp.i_req_valid = 1; bus_fp.d_mem_read = 1; bus_fp.m_req_ready = 1; bus_fp.m_rvalid = 1;
      bus_fp.i_rready = 1; bus_fp.d_rready = 1; bus_fp.m_rdata = $urandom;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.m_req_valid && rr.size() < 3) rr.push_back(int'(bus.d_req_ready));
         if (bus_fp.m_req_valid && fp.size() < 3) fp.push_back(int'(bus_fp.d_req_ready));
      end
      tests++;
      if (rr.size() != 3) begin
         fails++; $display("FAIL rr_grant_count: got %0d grants required 3", rr.size());
      end else begin
         // Round-robin after reset: fetch first, then alternating.
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (rr[k] != k % 2) begin
               fails++; $display("FAIL rr_grant_%0d: owner=%0d required %0d", k, rr[k], k % 2);
            end
         end
      end
      tests++;
      if (fp.size() != 3) begin
         fails++; $display("FAIL fp_grant_count: got %0d grants required 3", fp.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (fp[k] != 1) begin
               fails++; $display("FAIL fp_grant_%0d: owner=%0d required 1", k, fp[k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] a;
      logic [DW-1:0] r;
      do_reset();
      a = $urandom; r = $urandom;
      bus.d_addr = a; bus.d_mem_read = 1; bus.d_wdata = $urandom; bus.d_wstrb = 4'h3;
      @(negedge clk);
      repeat (5) begin
         #1;
         tests++;
         if ({bus.m_req_valid, bus.m_addr, bus.m_wen, bus.d_req_ready, bus.i_req_ready} !== {1'b1, a, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bp_req_hold: valid=%b addr=%h d_rdy=%b required 1 %h 0",
                     bus.m_req_valid, bus.m_addr, bus.d_req_ready, a);
         end
         @(negedge clk);
      end
      bus.m_req_ready = 1;
      #1;
      tests++;
      if (bus.d_req_ready !== 1'b1) begin
         fails++; $display("FAIL bp_accept: d_req_ready=%b required 1", bus.d_req_ready);
      end
      @(negedge clk);
      bus.d_mem_read = 0; bus.m_req_ready = 0; bus.m_rvalid = 1; bus.m_rdata = r; bus.d_rready = 0;
      repeat (3) begin
         #1;
         tests++;
         if ({bus.m_rready, bus.d_rvalid, bus.d_rdata, bus.i_rvalid} !== {1'b0, 1'b1, r, 1'b0}) begin
            fails++;
            $display("FAIL bp_resp_hold: m_rready=%b d_rvalid=%b d_rdata=%h required 0 1 %h",
                     bus.m_rready, bus.d_rvalid, bus.d_rdata, r);
         end
         @(negedge clk);
      end
      bus.d_rready = 1;
      #1;
      tests++;
      if (bus.m_rready !== 1'b1) begin
         fails++; $display("FAIL bp_rready: m_rready=%b required 1", bus.m_rready);
      end
      @(negedge clk);
      bus.m_rvalid = 0; bus.d_rready = 0;
      #1;
      tests++;
      if ({bus.d_rvalid, bus.m_req_valid} !== 2'b00) begin
         fails++; $display("FAIL bp_done: d_rvalid=%b m_req_valid=%b required 0 0", bus.d_rvalid, bus.m_req_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] a;
      do_reset();
      bus.d_addr = 32'h40; bus.d_mem_read = 1; bus.m_req_ready = 1;
      @(negedge clk);
      @(negedge clk);
      bus.d_mem_read = 0; bus.m_req_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h1234_5678; bus.d_rready = 0;
      #1;
      tests++;
      if (bus.d_rvalid !== 1'b1) begin
         fails++; $display("FAIL rstmid_in_resp: d_rvalid=%b required 1", bus.d_rvalid);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if ({bus.i_req_ready, bus.i_rvalid, bus.i_rdata, bus.d_req_ready, bus.d_rvalid, bus.d_rdata,
           bus.m_addr, bus.m_req_valid, bus.m_wen, bus.m_wdata, bus.m_wstrb, bus.m_rready} !== '0) begin
         fails++;
         $display("FAIL rstmid_outputs: d_rvalid=%b d_rdata=%h m_req_valid=%b required all 0",
                  bus.d_rvalid, bus.d_rdata, bus.m_req_valid);
      end
      rst = 1'b0;
      clear_inputs();
      a = $urandom;
      bus.d_addr = a; bus.d_mem_read = 1; bus.m_req_ready = 1;
      @(negedge clk);
      tests++;
      if ({bus.m_req_valid, bus.d_req_ready, bus.m_wen, bus.m_addr} !== {1'b1, 1'b1, 1'b0, a}) begin
         fails++;
         $display("FAIL rstmid_fresh_grant: valid=%b d_rdy=%b addr=%h required 1 1 %h",
                  bus.m_req_valid, bus.d_req_ready, bus.m_addr, a);
      end
   endtask

   // Memory-side handler for one granted transaction owned by channel ch.
   task automatic serve(input bit ch, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [SW-1:0] ws);
      int n;
      logic [DW-1:0] rd;
      logic [DW-1:0] ewd;
      logic [SW-1:0] ews;
      ewd = ch ? wd : '0;
      ews = ch ? ws : '0;
      n = 0;
      @(negedge clk);
      while (bus.m_req_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (bus.m_req_valid !== 1'b1) begin
         fails++; $display("FAIL serve_timeout: m_req_valid=%b required 1", bus.m_req_valid);
         return;
      end
      repeat ($urandom_range(0, 3)) begin
         tests++;
         if ({bus.i_req_ready, bus.d_req_ready} !== 2'b00) begin
            fails++; $display("FAIL serve_stall: i_rdy=%b d_rdy=%b required 0 0", bus.i_req_ready, bus.d_req_ready);
         end
         @(negedge clk);
      end
      bus.m_req_ready = 1;
      #1;
      tests++;
      if ({bus.i_req_ready, bus.d_req_ready} !== (ch ? 2'b01 : 2'b10)) begin
         fails++; $display("FAIL serve_owner: i_rdy=%b d_rdy=%b required owner %0d", bus.i_req_ready, bus.d_req_ready, ch);
      end
      tests++;
      if ({bus.m_addr, bus.m_wen, bus.m_wdata, bus.m_wstrb} !== {addr, wr, ewd, ews}) begin
         fails++;
         $display("FAIL serve_fields: addr=%h wen=%b wdata=%h wstrb=%h required %h %b %h %h",
                  bus.m_addr, bus.m_wen, bus.m_wdata, bus.m_wstrb, addr, wr, ewd, ews);
      end
      if (ch) m_pd++;
      else    m_pi++;
      @(negedge clk);
      bus.m_req_ready = 0;
      if (ch) begin bus.d_mem_read = 0; bus.d_mem_write = 0; end
      else    bus.i_req_valid = 0;
      if (wr) begin
         #1;
         tests++;
         if ({bus.m_req_valid, bus.m_rready, bus.i_rvalid, bus.d_rvalid} !== 4'b0000) begin
            fails++; $display("FAIL serve_write_done: valid=%b m_rready=%b d_rvalid=%b required 0 0 0",
                              bus.m_req_valid, bus.m_rready, bus.d_rvalid);
         end
         return;
      end
      repeat ($urandom_range(0, 2)) begin
         #1;
         tests++;
         if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
            fails++; $display("FAIL serve_resp_wait: i_rvalid=%b d_rvalid=%b required 0 0", bus.i_rvalid, bus.d_rvalid);
         end
         @(negedge clk);
      end
      rd = $urandom;
      bus.m_rvalid = 1; bus.m_rdata = rd;
      if (ch) bus.d_rready = 1;
      else    bus.i_rready = 1;
      #1;
      tests++;
      if ({bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata, bus.m_rready} !==
          (ch ? {1'b0, 32'h0, 1'b1, rd, 1'b1} : {1'b1, rd, 1'b0, 32'h0, 1'b1})) begin
         fails++;
         $display("FAIL serve_route: i_rvalid=%b i_rdata=%h d_rvalid=%b d_rdata=%h required owner %0d data %h",
                  bus.i_rvalid, bus.i_rdata, bus.d_rvalid, bus.d_rdata, ch, rd);
      end
      @(negedge clk);
      bus.m_rvalid = 0; bus.m_rdata = '0; bus.i_rready = 0; bus.d_rready = 0;
   endtask

   task automatic test_random();
      bit last;
      bit fr, both, win;
      int dop;
      logic [AW-1:0] ia, da;
      logic [DW-1:0] wd;
      logic [SW-1:0] ws;
      logic [31:0] e_pi, e_pd, e_pc;
      do_reset();
      last = 1'b1;
      for (int it = 0; it < 40; it++) begin
         fr  = 1'($urandom_range(0, 1));
         dop = $urandom_range(0, 3);
         if (!fr && dop == 0) fr = 1'b1;
         ia = $urandom; da = $urandom; wd = $urandom; ws = SW'($urandom);
         bus.i_addr = ia; bus.i_req_valid = fr;
         bus.d_addr = da; bus.d_wdata = wd; bus.d_wstrb = ws;
         bus.d_mem_read = (dop == 1 || dop == 3); bus.d_mem_write = (dop >= 2);
         both = fr && (dop != 0);
         win  = both ? ~last : (dop != 0);
         last = win;
         if (win) serve(1'b1, dop >= 2, da, wd, ws);
         else     serve(1'b0, 1'b0, ia, wd, ws);
         if (both) begin
            last = ~win;
            if (win) serve(1'b0, 1'b0, ia, wd, ws);
            else     serve(1'b1, dop >= 2, da, wd, ws);
         end
      end
      @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
      e_pi = m_pi; e_pd = m_pd; e_pc = m_conf;
`else
      e_pi = 0; e_pd = 0; e_pc = 0;
`endif
      tests++;
      if ({pi, pd, pc} !== {e_pi, e_pd, e_pc}) begin
         fails++;
         $display("FAIL perf_counters: got %0d/%0d/%0d required %0d/%0d/%0d", pi, pd, pc, e_pi, e_pd, e_pc);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fetch();
      test_store();
      test_conflict();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one downstream memory port between the core's instruction-fetch channel and its load/store channel. Both upstream channels use the same valid/ready request and response protocol as the core. The block sits between the multicycle core and the memory/bus bridge. It allows one transaction in flight at a time, arbitrates round-robin or by fixed priority, and routes each read response back to the requester that issued it.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W = DATA_W/8
FIXED_PRIO, 0, 0 = round-robin; 1 = data channel always wins a conflict

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_addr  in  ADDR_W  fetch address
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted
i_rdata  out  DATA_W  fetch response data
i_rvalid  out  1  fetch response valid
i_rready  in  1  core ready for fetch response
d_addr  in  ADDR_W  load/store address
d_mem_read  in  1  load request
d_mem_write  in  1  store request
d_wdata  in  DATA_W  store data
d_wstrb  in  STRB_W  store byte strobes
d_req_ready  out  1  data request accepted
d_rdata  out  DATA_W  load response data
d_rvalid  out  1  load response valid
d_rready  in  1  core ready for load response
m_addr  out  ADDR_W  downstream address
m_req_valid  out  1  downstream request valid
m_wen  out  1  downstream write
m_wdata  out  DATA_W  downstream write data
m_wstrb  out  STRB_W  downstream strobes
m_req_ready  in  1  downstream accepts request
m_rdata  in  DATA_W  downstream read data
m_rvalid  in  1  downstream read valid
m_rready  out  1  arbiter ready for read data
perf_i_grants  out  32  fetch grant count (see Optional Feature)
perf_d_grants  out  32  data grant count
perf_conflict  out  32  conflict cycle count

Behaviour:
- Requesters: fetch requests when i_req_valid=1. Data requests when d_mem_read or d_mem_write is 1. If both d_mem_read and d_mem_write are 1, the request is treated as a write.
- State machine: IDLE, REQ, RESP. Owner register `own`: 0 = fetch, 1 = data. Register `last`: last granted channel.
- IDLE:
  - No request: stay in IDLE.
  - One requester: own <= that requester, go to REQ.
  - Both request: FIXED_PRIO=1 grants data. FIXED_PRIO=0 grants the channel not equal to `last`. `last` <= granted channel.
  - Grant costs exactly 1 cycle; m_req_valid first rises the cycle after the request appears.
- REQ:
  - m_req_valid=1. m_addr, m_wen, m_wdata and m_wstrb are combinationally muxed from the owner's inputs.
  - Fetch owner drives m_wen=0, m_wdata=0, m_wstrb=0.
  - Owner's req_ready = m_req_ready; the non-owner's req_ready = 0.
  - Upstream must hold its request stable until req_ready.
  - On m_req_ready: write -> IDLE, with no response phase and no rvalid to the core. Read -> RESP.
- RESP:
  - Owner's rvalid = m_rvalid; owner's rdata = m_rdata.
  - m_rready = owner's rready.
  - On m_rvalid & m_rready -> IDLE.
- Non-owner, and any state other than RESP: rvalid=0, rdata=0.
- Outputs in IDLE: m_req_valid, m_wen, m_rready, all req_ready and rvalid = 0. m_addr, m_wdata and m_wstrb = 0.
- Back-to-back: minimum 3 cycles per read transaction (grant, request, response), 2 per write.
- Reset:
  - state <= IDLE; last <= data, so fetch wins the first conflict.
  - All outputs 0 the cycle after rst.
  - Reset mid-REQ or mid-RESP abandons the transaction. The downstream is reset by the same rst.
- Requests arriving in REQ/RESP wait; they are re-arbitrated in IDLE.

Optional Feature:
Macro MEM_ARB_PERF_CNT_EN.
- Defined: three 32-bit counters, reset to 0, wrapping at 2^32.
  - perf_i_grants: +1 per IDLE->REQ with fetch owner.
  - perf_d_grants: +1 per IDLE->REQ with data owner.
  - perf_conflict: +1 per cycle in any state where both channels request and at least one is not being served in that cycle.
- Undefined: the perf ports remain, tied to constant 0; no counter flops.

Test Plan:
- Fetch only: i_addr=0x80000000, m_req_ready=1, then m_rvalid=1 with m_rdata=0x00000013.
  -> m_req_valid at cycle+1 with m_addr=0x80000000, m_wen=0. Then i_rvalid=1, i_rdata=0x13, d_rvalid=0. IDLE after the handshake.
- Store: d_mem_write=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF.
  -> m_wen=1 with the same fields; d_req_ready pulses 1 cycle with m_req_ready. No RESP, m_rready stays 0, back to IDLE.
- Post-reset conflict, FIXED_PRIO=0, both channels requesting reads continuously.
  -> Grant order is fetch, data, fetch. With FIXED_PRIO=1 every grant goes to data.
- Backpressure: m_req_ready=0 for 5 cycles.
  -> m_req_valid held 1, fields stable, req_ready=0.
  -> Then m_rvalid=1 with d_rready=0 for 3 cycles: m_rready=0, d_rvalid=1, state held.
- rst asserted during RESP.
  -> Next cycle: state IDLE, all outputs 0. A fresh d_mem_read is granted normally, data first only if fetch is idle.
- With MEM_ARB_PERF_CNT_EN: 2 fetch reads, 1 store, one 1-cycle simultaneous request.
  -> perf_i_grants=2, perf_d_grants=1, perf_conflict >= 1. Without the macro all three read 0.
